// File: rtl/multi_clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider: parameter defaults,
// the per-channel update mode and the divisor helper functions.
package multi_clk_div_pkg;

    localparam int DIV_W_DEFAULT   = 8;
    localparam int RST_DIV_DEFAULT = 2;

    // What a channel does on the coming edge
    typedef enum logic [1:0] {
        CH_OFF,      // disabled: parked at cnt 0, outputs low
        CH_RESTART,  // start a fresh period at cnt 0 (enable, sync, halted)
        CH_RUN       // free-running count
    } chanMode_e;

    // Divisor actually used: 0 halts, 1 is promoted to 2, anything else as-is
    function automatic logic [31:0] effDiv(input logic [31:0] divVal);
        return (divVal == 32'd1) ? 32'd2 : divVal;
    endfunction

    // Number of high cycles per period, ceil(effVal/2)
    function automatic logic [31:0] highCount(input logic [31:0] effVal);
        return (effVal + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/multi_clk_div_if.sv
// Control and status bundle for multi_clk_div. The master side drives enables,
// divisors and strobes; the slave side (the divider) returns the clocks.
interface multi_clk_div_if
    import multi_clk_div_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DIV_W = DIV_W_DEFAULT
);

    logic [NCH-1:0]       en;
    logic [NCH*DIV_W-1:0] div_val;
    logic [NCH-1:0]       div_load;
    logic                 sync_all;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       pending;

    modport master (
        output en, div_val, div_load, sync_all,
        input  clk_out, tick, pending
    );

    modport slave (
        input  en, div_val, div_load, sync_all,
        output clk_out, tick, pending
    );

endinterface

// File: rtl/multi_clk_div_chan.sv
// One divider channel: active divisor, shadow divisor and period counter.
// Outputs are computed from the next-state values and registered, so they
// always describe the counter value held in the same cycle.
module clk_div_chan
    import multi_clk_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEFAULT,
    parameter int RST_DIV = RST_DIV_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_val_i,
    input  logic             div_load_i,
    input  logic             sync_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             pending_o
);

    logic [DIV_W-1:0] divActive_q, divActive_d;
    logic [DIV_W-1:0] divShadow_q, divShadow_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             started_q, started_d;
    logic             clkOut_q, clkOut_d;
    logic             tick_q, tick_d;

    chanMode_e        mode;
    logic [DIV_W-1:0] newVal;
    logic             hasNew;
    logic [31:0]      effCur;
    logic [31:0]      effNext;

    // Next-state: pick the mode, move the counter, swap in a shadow divisor
    // only where a period boundary (or no period at all) allows it
    always_comb begin
        divActive_d = divActive_q;
        divShadow_d = divShadow_q;
        pending_d   = pending_q;
        cnt_d       = '0;
        newVal      = div_load_i ? div_val_i : divShadow_q;
        hasNew      = div_load_i | pending_q;
        effCur      = effDiv(32'(divActive_q));

        if (div_load_i) begin
            divShadow_d = div_val_i;
            pending_d   = 1'b1;
        end

        // started_q is low after reset, while disabled and while halted, so
        // the first usable edge always opens a fresh period at cnt 0
        if (!en_i) begin
            mode = CH_OFF;
        end else if (sync_i || !started_q) begin
            mode = CH_RESTART;
        end else begin
            mode = CH_RUN;
        end

        case (mode)
            CH_OFF, CH_RESTART: begin
                cnt_d = '0;
                if (hasNew) begin
                    divActive_d = newVal;
                    pending_d   = 1'b0;
                end
            end
            default: begin
                if (32'(cnt_q) == effCur - 32'd1) begin
                    cnt_d = '0;
                    if (hasNew) begin
                        divActive_d = newVal;
                        pending_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        effNext   = effDiv(32'(divActive_d));
        started_d = en_i && (effNext != 32'd0);
        clkOut_d  = started_d && (32'(cnt_d) < highCount(effNext));
        tick_d    = started_d && (32'(cnt_d) == effNext - 32'd1);
    end

    // State and output registers, cleared asynchronously to the reset divisor
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            divActive_q <= DIV_W'(RST_DIV);
            divShadow_q <= DIV_W'(RST_DIV);
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            started_q   <= 1'b0;
            clkOut_q    <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            divActive_q <= divActive_d;
            divShadow_q <= divShadow_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            started_q   <= started_d;
            clkOut_q    <= clkOut_d;
            tick_q      <= tick_d;
        end
    end

    assign clk_out_o = clkOut_q;
    assign tick_o    = tick_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider: NCH independent channels that
// share only the clock, reset and the sync_all phase-alignment strobe.
module multi_clk_div
    import multi_clk_div_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int DIV_W   = DIV_W_DEFAULT,
    parameter int RST_DIV = RST_DIV_DEFAULT
) (
    input  logic           clk_100MHz,
    input  logic           rst_n,
    multi_clk_div_if.slave bus
);

    logic [NCH-1:0] clkOut;
    logic [NCH-1:0] tickOut;
    logic [NCH-1:0] pendingOut;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_div_chan #(
            .DIV_W   (DIV_W),
            .RST_DIV (RST_DIV)
        ) u_chan (
            .clk_i      (clk_100MHz),
            .rst_ni     (rst_n),
            .en_i       (bus.en[i]),
            .div_val_i  (bus.div_val[i*DIV_W +: DIV_W]),
            .div_load_i (bus.div_load[i]),
            .sync_i     (bus.sync_all),
            .clk_out_o  (clkOut[i]),
            .tick_o     (tickOut[i]),
            .pending_o  (pendingOut[i])
        );
    end

    assign bus.clk_out = clkOut;
    assign bus.tick    = tickOut;
    assign bus.pending = pendingOut;

endmodule
